max7219_frame_sequencer: RTL and testbench

//  Sequences frames from a pattern generator (e.g. pattern_conwaylife) onto a MAX7219 daisy-chain serializer.

---
 rtl/max7219_pkg.sv | 24 ++
 rtl/max7219_init_rom.sv | 26 ++
 rtl/max7219_frame_sequencer.sv | 160 ++++++++++++++++
 tb/tb_max7219_frame_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// Shared MAX7219 register map, command-word helper and sequencer state type.
package max7219_pkg;

  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DIGIT1    = 4'h2;
  localparam logic [3:0] REG_DIGIT2    = 4'h3;
  localparam logic [3:0] REG_DIGIT3    = 4'h4;
  localparam logic [3:0] REG_DIGIT4    = 4'h5;
  localparam logic [3:0] REG_DIGIT5    = 4'h6;
  localparam logic [3:0] REG_DIGIT6    = 4'h7;
  localparam logic [3:0] REG_DIGIT7    = 4'h8;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCAN      = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  typedef enum logic [2:0] {INIT, IDLE, INTEN, LATCH, SEND} state_t;

  function automatic logic [15:0] cmd_word(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

endpackage

// File: rtl/max7219_init_rom.sv
// Chip initialisation command table: index -> 16-bit MAX7219 word, with last-entry flag.
module max7219_init_rom
  import max7219_pkg::*;
(
  input  logic [2:0]  cmd_idx,
  input  logic [3:0]  intensity,
  output logic [15:0] word,
  output logic        last
);

  always_comb begin
    word = '0;
    last = 1'b0;
    case (cmd_idx)
      3'd0:    word = cmd_word(REG_SHUTDOWN, 8'h01);
      3'd1:    word = cmd_word(REG_DECODE, 8'h00);
      3'd2:    word = cmd_word(REG_SCAN, 8'h07);
      3'd3:    word = cmd_word(REG_INTENSITY, {4'h0, intensity});
      default: begin
        word = cmd_word(REG_TEST, 8'h00);
        last = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/max7219_frame_sequencer.sv
// Feeds init commands, intensity updates and latched frames, one digit register per
// chain load, to a MAX7219 daisy-chain serializer over a valid/ready handshake.
module max7219_frame_sequencer
  import max7219_pkg::*;
#(
  parameter int unsigned DISP_ROWS     = 1,
  parameter int unsigned DISP_COLUMNS  = 1,
  parameter int unsigned REINIT_FRAMES = 64
) (
  input  logic                                                i_Clk,
  input  logic                                                i_Rst,
  input  logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0]  i_Frame,
  input  logic                                                i_FrameValid,
  output logic                                                o_FrameAck,
  input  logic [3:0]                                          i_Intensity,
  output logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0]       o_Chain,
  output logic                                                o_ChainValid,
  input  logic                                                i_ChainReady,
  output logic                                                o_InitDone,
  output logic                                                o_Busy
);

  localparam int unsigned CNT_W = (REINIT_FRAMES == 0) ? 1 : $clog2(REINIT_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REINIT_FRAMES);

  state_t state, state_n;
  logic                                               active;
  logic [2:0]                                         cmd_idx;
  logic [2:0]                                         digit;
  logic [CNT_W-1:0]                                   frame_cnt;
  logic [3:0]                                         last_inten;
  logic [3:0]                                         inten_hold;
  logic                                               inten_held;
  logic                                               init_done;
  logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0]  frame_buf;

  logic        xfer;
  logic        reinit_due;
  logic        is_inten_word;
  logic [3:0]  inten_eff;
  logic [15:0] rom_word;
  logic        rom_last;
  logic [15:0] bcast_word;

  // Intensity is taken live on the first cycle its word is offered, then frozen
  // so the word cannot change while the serializer stalls.
  assign inten_eff     = inten_held ? inten_hold : i_Intensity;
  assign xfer          = o_ChainValid & i_ChainReady;
  assign reinit_due    = (REINIT_FRAMES != 0) && (frame_cnt == CNT_MAX);
  assign is_inten_word = ((state == INIT) && (cmd_idx == 3'd3)) || (state == INTEN);

  max7219_init_rom u_init_rom (
    .cmd_idx   (cmd_idx),
    .intensity (inten_eff),
    .word      (rom_word),
    .last      (rom_last)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      state <= INIT;
    end else if (active) begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      INIT:    if (xfer && rom_last) state_n = IDLE;
      IDLE: begin
        if (reinit_due)                     state_n = INIT;
        else if (i_Intensity != last_inten) state_n = INTEN;
        else if (i_FrameValid)              state_n = LATCH;
      end
      INTEN:   if (xfer) state_n = IDLE;
      LATCH:   state_n = SEND;
      SEND:    if (xfer && (digit == 3'd7)) state_n = IDLE;
      default: state_n = INIT;
    endcase
  end

  always_comb begin
    bcast_word   = '0;
    o_ChainValid = 1'b0;
    o_FrameAck   = 1'b0;
    if (active) begin
      case (state)
        INIT: begin
          o_ChainValid = 1'b1;
          bcast_word   = rom_word;
        end
        INTEN: begin
          o_ChainValid = 1'b1;
          bcast_word   = cmd_word(REG_INTENSITY, {4'h0, inten_eff});
        end
        LATCH:   o_FrameAck = 1'b1;
        SEND:    o_ChainValid = 1'b1;
        default: ;
      endcase
    end
    for (int unsigned r = 0; r < DISP_ROWS; r++) begin
      for (int unsigned c = 0; c < DISP_COLUMNS; c++) begin
        o_Chain[r][c] = bcast_word;
      end
    end
    if (active && (state == SEND)) o_Chain = frame_buf[digit];
  end

  assign o_Busy     = active && (state != IDLE);
  assign o_InitDone = init_done;

  // active holds outputs quiet for the cycle in which reset is released.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      active     <= 1'b0;
      cmd_idx    <= '0;
      digit      <= '0;
      frame_cnt  <= '0;
      last_inten <= '0;
      inten_hold <= '0;
      inten_held <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      active <= 1'b1;
      if (active) begin
        case (state)
          INIT: if (xfer) begin
            cmd_idx <= rom_last ? '0 : cmd_idx + 3'd1;
            if (rom_last) init_done <= 1'b1;
          end
          IDLE: if (reinit_due) begin
            frame_cnt <= '0;
            cmd_idx   <= '0;
          end
          LATCH: digit <= '0;
          SEND: if (xfer) begin
            digit <= digit + 3'd1;
            if ((digit == 3'd7) && (frame_cnt != CNT_MAX)) frame_cnt <= frame_cnt + 1'b1;
          end
          default: ;
        endcase
        if (is_inten_word && o_ChainValid) begin
          if (xfer) begin
            inten_held <= 1'b0;
            last_inten <= inten_eff;
          end else begin
            inten_held <= 1'b1;
            inten_hold <= inten_eff;
          end
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (active && (state == LATCH)) frame_buf <= i_Frame;
  end

endmodule

// File: tb/tb_max7219_frame_sequencer.sv
// Bench for max7219_frame_sequencer (2x2 chips, re-init every 2 frames): transfer-level
// reference model checked every cycle, plus directed literal expectations.
module tb_max7219_frame_sequencer;
  localparam int unsigned R  = 2;
  localparam int unsigned C  = 2;
  localparam int unsigned RF = 2;

  typedef logic [0:7][R-1:0][C-1:0][15:0] frame_t;
  typedef logic [R-1:0][C-1:0][15:0]      chain_t;

  logic       clk, rst_n, fv, ready, ack, cvalid, idone, busy;
  logic [3:0] intensity;
  frame_t     frame;
  chain_t     chain;

  max7219_frame_sequencer #(
    .DISP_ROWS     (R),
    .DISP_COLUMNS  (C),
    .REINIT_FRAMES (RF)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst_n),
    .i_Frame      (frame),
    .i_FrameValid (fv),
    .o_FrameAck   (ack),
    .i_Intensity  (intensity),
    .o_Chain      (chain),
    .o_ChainValid (cvalid),
    .i_ChainReady (ready),
    .o_InitDone   (idone),
    .o_Busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic        rst_edge = 1'b0;
  logic        rand_ready = 1'b0;
  int          phase = 1;   // 0 idle/between jobs, 1 init sequence, 2 frame
  int          k = 0;
  int unsigned cnt = 0;
  logic [3:0]  last_sent = '0;
  logic [3:0]  emit_int = '0;
  logic [3:0]  int_prev = '0;
  logic        fv_prev = 1'b0;
  logic        idone_exp = 1'b0;
  logic        prev_pending = 1'b0;
  chain_t      prev_chain;
  frame_t      snap;
  int          acks = 0;
  int          frames_done = 0;
  int          reinits = 0;
  logic [15:0] xlog[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] init_word(input int idx, input logic [3:0] i);
    case (idx)
      0:       return 16'h0C01;
      1:       return 16'h0900;
      2:       return 16'h0B07;
      3:       return {12'h0A0, i};
      default: return 16'h0F00;
    endcase
  endfunction

  function automatic chain_t bcast(input logic [15:0] w);
    chain_t b;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) b[r][c] = w;
    return b;
  endfunction

  function automatic logic [15:0] logat(input int i);
    if (xlog.size() > i) return xlog[i];
    return 16'hxxxx;
  endfunction

  always @(posedge clk) rst_edge <= rst_n;

  // Reference model: tracks what the next transfer must be from the observed handshakes.
  always @(negedge clk) begin
    if (!rst_edge) begin
      chk("rst_valid", cvalid, 1'b0);
      chk("rst_chain", chain, '0);
      chk("rst_ack", ack, 1'b0);
      chk("rst_initdone", idone, 1'b0);
      chk("rst_busy", busy, 1'b0);
      phase = 1; k = 0; cnt = 0; idone_exp = 1'b0; prev_pending = 1'b0;
    end else begin
      chk("init_done", idone, idone_exp);
      if (prev_pending) begin
        chk("hold_valid", cvalid, 1'b1);
        chk("hold_chain", chain, prev_chain);
      end
      if (cvalid && !prev_pending) emit_int = intensity;
      if (cvalid) chk("busy_when_valid", busy, 1'b1);
      if (ack) begin
        chk("ack_when_idle", phase, 0);
        chk("ack_had_request", fv_prev, 1'b1);
        chk("ack_inten_prio", int_prev, last_sent);
        chk("ack_reinit_prio", (cnt == RF), 1'b0);
        acks++;
        snap = frame;
        phase = 2; k = 0;
      end
      if (cvalid && ready) begin
        xlog.push_back(chain[0][0]);
        case (phase)
          1: begin
            chk("init_word", chain, bcast(init_word(k, emit_int)));
            if (k == 3) last_sent = emit_int;
            k++;
            if (k == 5) begin phase = 0; idone_exp = 1'b1; end
          end
          2: begin
            chk("frame_word", chain, snap[k]);
            k++;
            if (k == 8) begin
              phase = 0;
              frames_done++;
              if (cnt < RF) cnt++;
            end
          end
          default: begin
            if (chain[0][0] == 16'h0C01) begin
              chk("reinit_due", cnt, RF);
              chk("reinit_word", chain, bcast(16'h0C01));
              cnt = 0; reinits++;
              phase = 1; k = 1;
            end else begin
              chk("inten_word", chain, bcast(init_word(3, emit_int)));
              chk("inten_reinit_prio", (cnt == RF), 1'b0);
              last_sent = emit_int;
            end
          end
        endcase
      end
      prev_pending = cvalid && !ready;
      prev_chain   = chain;
    end
    int_prev = intensity;
    fv_prev  = fv;
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) ready = ($urandom_range(3) != 0);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input frame_t f, output int lat);
    frame = f; fv = 1'b1; lat = -1;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (ack) begin lat = n; tick(); fv = 1'b0; return; end
    end
    chk("ack_timeout", 1'b0, 1'b1);
    fv = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    for (int n = 0; n < 600 && frames_done < target; n++) tick();
    chk("frame_timeout", frames_done >= target, 1'b1);
  endtask

  task automatic wait_digit(input logic [15:0] w);
    int n;
    for (n = 0; n < 100 && !(cvalid && chain[0][0] == w); n++) tick();
    chk("digit_timeout", cvalid && chain[0][0] == w, 1'b1);
  endtask

  function automatic frame_t make_frame();
    frame_t f;
    for (int d = 0; d < 8; d++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          f[d][r][c] = (r == 0 && c == 0) ? {4'h0, 4'(d + 1), 8'h01} : 16'($urandom);
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int d = 0; d < 8; d++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) f[d][r][c] = 16'($urandom);
    return f;
  endfunction

  initial begin
    int lat, fd, a0, n;
    rst_n = 1'b0; fv = 1'b0; ready = 1'b1; intensity = 4'd4; frame = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Power-up init sequence.
    for (n = 0; n < 100 && !idone; n++) tick();
    chk("init_timeout", idone, 1'b1);
    chk("init_len", xlog.size(), 5);
    chk("init0", logat(0), 16'h0C01);
    chk("init1", logat(1), 16'h0900);
    chk("init2", logat(2), 16'h0B07);
    chk("init3", logat(3), 16'h0A04);
    chk("init4", logat(4), 16'h0F00);

    // Plain frame: latency, ordering.
    tick(); xlog.delete(); a0 = acks; fd = frames_done;
    send_frame(make_frame(), lat);
    chk("ack_latency", lat, 1);
    chk("first_digit", {cvalid, chain[0][0]}, {1'b1, 16'h0101});
    wait_frames(fd + 1);
    chk("one_ack", acks - a0, 1);
    chk("frame_len", xlog.size(), 8);
    for (int d = 0; d < 8; d++) chk("frame_order", logat(d), {4'h0, 4'(d + 1), 8'h01});

    // Serializer stall on digit 2.
    xlog.delete(); fd = frames_done;
    send_frame(make_frame(), lat);
    wait_digit(16'h0301);
    ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_valid", cvalid, 1'b1);
      chk("stall_word", chain[0][0], 16'h0301);
    end
    ready = 1'b1;
    wait_frames(fd + 1);
    chk("stall_d2", logat(2), 16'h0301);
    chk("stall_d3", logat(3), 16'h0401);
    chk("stall_len", xlog.size(), 8);

    // Two frames done: forced re-init follows.
    for (n = 0; n < 100 && !(reinits == 1 && phase == 0); n++) tick();
    chk("reinit_count", reinits, 1);

    // Intensity change mid-frame is deferred until the frame completes.
    tick(); xlog.delete(); fd = frames_done;
    send_frame(make_frame(), lat);
    wait_digit(16'h0301);
    intensity = 4'd9;
    for (n = 0; n < 100 && xlog.size() < 9; n++) tick();
    chk("defer_frame_end", logat(7), 16'h0801);
    chk("defer_inten", logat(8), 16'h0A09);
    send_frame(make_frame(), lat);
    wait_frames(fd + 2);
    chk("no_repeat_inten", logat(9), 16'h0101);
    chk("defer_len", xlog.size(), 17);

    // Reset mid-frame, then a request dropped before it is acknowledged.
    frame = make_frame(); fv = 1'b1;
    wait_digit(16'h0601);
    rst_n = 1'b0; fv = 1'b0;
    tick();
    chk("rst_mid_valid", cvalid, 1'b0);
    chk("rst_mid_initdone", idone, 1'b0);
    rst_n = 1'b1; xlog.delete(); a0 = acks;
    fv = 1'b1; tick(); tick(); fv = 1'b0;
    for (n = 0; n < 100 && !idone; n++) tick();
    repeat (4) tick();
    chk("dropped_no_ack", acks - a0, 0);
    chk("rst_restart", logat(0), 16'h0C01);
    chk("rst_restart_len", xlog.size(), 5);

    // Randomised traffic with back-pressure and intensity changes.
    rand_ready = 1'b1; fd = frames_done;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(2) == 0) intensity = 4'($urandom_range(15));
      send_frame(rand_frame(), lat);
      if ($urandom_range(3) == 0) intensity = 4'($urandom_range(15));
      repeat ($urandom_range(4)) tick();
    end
    wait_frames(fd + 30);
    rand_ready = 1'b0; ready = 1'b1;
    repeat (20) tick();
    chk("random_frames", frames_done - fd, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
